// File: rtl/instr_fetch_queue_if.sv
// instr_fetch_queue_if
//   Bundles the fetch-side and decode-side signals of the instruction fetch queue.
//   master : the fetch/decode environment. It drives flush, the in_* entry and out_ready.
//   slave  : the queue itself. It drives in_ready, the out_* head entry and count.
//   PTR_W  : log2 of the queue depth. count is PTR_W+1 bits wide so it can hold the value DEPTH.
interface instr_fetch_queue_if #(
    parameter int PTR_W = 2
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_pc;
    logic [31:0]      in_instr;
    logic             in_adel;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_pc;
    logic [31:0]      out_instr;
    logic             out_adel;
    logic [PTR_W:0]   count;

    modport master (
        output flush, in_valid, in_pc, in_instr, in_adel, out_ready,
        input  in_ready, out_valid, out_pc, out_instr, out_adel, count
    );

    modport slave (
        input  flush, in_valid, in_pc, in_instr, in_adel, out_ready,
        output in_ready, out_valid, out_pc, out_instr, out_adel, count
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue
//   Elastic FIFO between the I-cache response and decode. It holds
//   {pc, instr, adel} entries in program order and presents the oldest one to decode.
//   A flush discards every entry in one cycle.
// Ports:
//   clk    : rising-edge clock
//   resetn : synchronous reset, active low. It takes priority over flush, push and pop.
//   q      : instr_fetch_queue_if.slave, carrying flush, the in_* push side,
//            the out_* pop side and count.
// Optional build macro:
//   FETCH_QUEUE_BYPASS_EN : when the queue is empty, an incoming entry is shown to
//   decode in the same cycle. If decode takes it, the entry is never written.
module instr_fetch_queue #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                clk,
    input  logic                resetn,
    instr_fetch_queue_if.slave  q
);

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [DEPTH-1:0] adel_mem;

    logic [PTR_W:0]   wptr;
    logic [PTR_W:0]   rptr;
    logic [PTR_W:0]   cnt_q;

    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             bypass_take;

    logic [PTR_W-1:0] widx;
    logic [PTR_W-1:0] ridx;

    assign widx  = wptr[PTR_W-1:0];
    assign ridx  = rptr[PTR_W-1:0];
    assign empty = (wptr == rptr);
    assign full  = (widx == ridx) && (wptr[PTR_W] != rptr[PTR_W]);

    assign q.in_ready = ~full;
    assign q.count    = cnt_q;

`ifdef FETCH_QUEUE_BYPASS_EN
    // An entry that decode consumes straight off the inputs skips the storage entirely.
    assign bypass_take = empty & q.in_valid & q.out_ready & ~q.flush;
`else
    assign bypass_take = 1'b0;
`endif

    assign push = q.in_valid & ~full & ~q.flush & ~bypass_take;
    // Only stored entries advance rptr. A bypassed entry leaves the pointers untouched.
    assign pop  = ~empty & q.out_ready & ~q.flush;

    // The head outputs are forced to zero (a NOP) whenever nothing is valid,
    // so decode never sees stale storage.
    always_comb begin
        q.out_valid = 1'b0;
        q.out_pc    = 32'h0;
        q.out_instr = 32'h0;
        q.out_adel  = 1'b0;
        if (!empty) begin
            q.out_valid = 1'b1;
            q.out_pc    = pc_mem[ridx];
            q.out_instr = instr_mem[ridx];
            q.out_adel  = adel_mem[ridx];
        end
`ifdef FETCH_QUEUE_BYPASS_EN
        else if (q.in_valid && !q.flush) begin
            q.out_valid = 1'b1;
            q.out_pc    = q.in_pc;
            q.out_instr = q.in_instr;
            q.out_adel  = q.in_adel;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt_q <= '0;
        end else if (q.flush) begin
            wptr  <= '0;
            rptr  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    // Storage has no reset. Its contents only matter between wptr and rptr.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[widx]    <= q.in_pc;
            instr_mem[widx] <= q.in_instr;
            adel_mem[widx]  <= q.in_adel;
        end
    end

endmodule

// File: tb/tb_instr_fetch_queue.sv
module tb_instr_fetch_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;
`ifdef FETCH_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } ent_t;

    logic clk = 1'b0;
    logic resetn;
    int   checks = 0;
    int   errors = 0;
    ent_t mq[$];

    always #5 clk = ~clk;

    instr_fetch_queue_if #(.PTR_W(PTR_W)) ifq ();

    instr_fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk    (clk),
        .resetn (resetn),
        .q      (ifq)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle. Inputs are applied just after a rising edge. Outputs are checked
    // against the queue model at the falling edge. The model then applies the
    // handshake rules for the coming edge.
    task automatic cyc(input logic rn, input logic fl, input logic iv,
                       input logic [31:0] pc, input logic [31:0] ins,
                       input logic ad, input logic ordy);
        int          n;
        logic        full_e, byp_e, ov_e;
        ent_t        h;
        logic [31:0] diff;
        resetn        = rn;
        ifq.flush     = fl;
        ifq.in_valid  = iv;
        ifq.in_pc     = pc;
        ifq.in_instr  = ins;
        ifq.in_adel   = ad;
        ifq.out_ready = ordy;
        @(negedge clk);
        n      = mq.size();
        full_e = (n == DEPTH);
        byp_e  = BYP && (n == 0) && iv && !fl;
        ov_e   = (n > 0) || byp_e;
        if (n > 0)      h = mq[0];
        else if (byp_e) h = '{pc, ins, ad};
        else            h = '{32'h0, 32'h0, 1'b0};
        chk("out_valid", {31'h0, ifq.out_valid}, {31'h0, ov_e});
        chk("in_ready",  {31'h0, ifq.in_ready},  {31'h0, ~full_e});
        chk("count",     {29'h0, ifq.count},     n);
        chk("out_pc",    ifq.out_pc,    h.pc);
        chk("out_instr", ifq.out_instr, h.instr);
        chk("out_adel",  {31'h0, ifq.out_adel},  {31'h0, h.adel});
        diff = {29'h0, 3'(dut.wptr - dut.rptr)};
        chk("ptr_diff",  diff, n);
        checks++;
        assert (ifq.count <= DEPTH) else begin
            errors++;
            $error("FAIL count_bound observed=%0d expected<=%0d", ifq.count, DEPTH);
        end
        if (!rn || fl) begin
            mq.delete();
        end else if (!(byp_e && ordy)) begin
            if (ov_e && ordy) void'(mq.pop_front());
            if (iv && !full_e) mq.push_back('{pc, ins, ad});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) cyc(1, 0, 0, 32'h0, 32'h0, 0, 0);
    endtask

    initial begin
        resetn        = 1'b0;
        ifq.flush     = 1'b0;
        ifq.in_valid  = 1'b0;
        ifq.in_pc     = 32'h0;
        ifq.in_instr  = 32'h0;
        ifq.in_adel   = 1'b0;
        ifq.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        idle(2);

        // fill to full, try a fifth push, then drain in order
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 1, 32'hBFC0_0000 + 4 * i, 32'h1000_0000 + i, 0, 0);
        cyc(1, 0, 1, 32'hBFC0_0010, 32'hDEAD_BEEF, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 0, 32'h0, 32'h0, 0, 1);
        idle(1);

        // streaming push and pop
        for (int i = 0; i < 20; i++)
            cyc(1, 0, 1, 32'hBFC0_1000 + 4 * i, $urandom, 0, 1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 32'h0, 32'h0, 0, 1);

        // flush with a same-cycle push and pop
        for (int i = 0; i < 3; i++)
            cyc(1, 0, 1, 32'hBFC0_2000 + 4 * i, $urandom, 0, 0);
        cyc(1, 1, 1, 32'hBADB_AD00, 32'hBADB_AD01, 1, 1);
        idle(2);
        cyc(1, 0, 0, 32'h0, 32'h0, 0, 1);

        // fetch exception flag travels with its entry
        cyc(1, 0, 1, 32'hBFC0_0002, 32'h0000_0013, 1, 0);
        cyc(1, 0, 0, 32'h0, 32'h0, 0, 0);
        cyc(1, 0, 0, 32'h0, 32'h0, 0, 1);
        idle(1);

        // reset while full
        for (int i = 0; i < 4; i++)
            cyc(1, 0, 1, 32'hBFC0_3000 + 4 * i, $urandom, 0, 0);
        cyc(0, 0, 1, 32'hBFC0_3010, 32'h0, 0, 1);
        idle(2);

        // random traffic
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 2) != 0), $urandom, $urandom,
                1'($urandom_range(0, 1)), ($urandom_range(0, 2) != 0));
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
